// File: rtl/fb_pipeline_pkg.sv
// Shared pipeline constants: hazard FSM state encodings and operand forward-select codes.
package fb_pipeline_pkg;

   localparam int unsigned STATE_W   = 2;
   localparam int unsigned FWD_W     = 2;
   localparam int unsigned MUL_CNT_W = 4;

   localparam logic [STATE_W-1:0] ST_IDLE       = 2'd0;
   localparam logic [STATE_W-1:0] ST_LOAD_STALL = 2'd1;
   localparam logic [STATE_W-1:0] ST_MUL_WAIT   = 2'd2;
   localparam logic [STATE_W-1:0] ST_MEM_WAIT   = 2'd3;

   localparam logic [FWD_W-1:0] FWD_RF    = 2'b00;
   localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b01;
   localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b10;

endpackage

// File: rtl/fb_fwd_select.sv
// Operand forward select for one EX source slot; the youngest producer (EX/MEM) wins, x0 is never forwarded.
module fb_fwd_select
   import fb_pipeline_pkg::*;
#(
   parameter int unsigned REG_AW = 5
) (
   input  logic [REG_AW-1:0] rs,
   input  logic              ex_mem_regwrite,
   input  logic [REG_AW-1:0] ex_mem_rd,
   input  logic              mem_wb_regwrite,
   input  logic [REG_AW-1:0] mem_wb_rd,
   output logic [FWD_W-1:0]  sel_c
);

   always_comb begin
      sel_c = FWD_RF;
      if (ex_mem_regwrite && (ex_mem_rd != '0) && (ex_mem_rd == rs)) begin
         sel_c = FWD_EXMEM;
      end else if (mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == rs)) begin
         sel_c = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/fb_hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use and multiplier scoreboard stalls,
// and data-memory wait handling, with a small debug FSM tracking the stall cause.
module fb_hazard_unit
   import fb_pipeline_pkg::*;
#(
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned MUL_LAT = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_SRC*REG_AW-1:0] if_id_rs,
   input  logic [NUM_SRC*REG_AW-1:0] id_ex_rs,
   input  logic                      id_ex_memread,
   input  logic                      id_ex_mul,
   input  logic [REG_AW-1:0]         id_ex_rd,
   input  logic                      ex_mem_regwrite,
   input  logic [REG_AW-1:0]         ex_mem_rd,
   input  logic                      mem_wb_regwrite,
   input  logic [REG_AW-1:0]         mem_wb_rd,
   input  logic                      dmem_ready,
   output logic [NUM_SRC*FWD_W-1:0]  forward_sel,
   output logic                      stall_if,
   output logic                      stall_id,
   output logic                      flush_ex,
   output logic                      stall_mem,
   output logic                      mul_busy,
   output logic [STATE_W-1:0]        state_o
);

   logic [STATE_W-1:0]   state_q,   state_d;
   logic [MUL_CNT_W-1:0] mul_cnt_q, mul_cnt_d;
   logic [REG_AW-1:0]    mul_rd_q,  mul_rd_d;

   logic ld_match_c;
   logic mul_match_c;
   logic load_use_c;
   logic mul_haz_c;

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_fwd
      fb_fwd_select #(
         .REG_AW (REG_AW)
      ) u_fwd (
         .rs              (id_ex_rs[k*REG_AW +: REG_AW]),
         .ex_mem_regwrite (ex_mem_regwrite),
         .ex_mem_rd       (ex_mem_rd),
         .mem_wb_regwrite (mem_wb_regwrite),
         .mem_wb_rd       (mem_wb_rd),
         .sel_c           (forward_sel[k*FWD_W +: FWD_W])
      );
   end

   // Busy is masked while rst is high so reset-time outputs never see stale tracking.
   assign mul_busy  = (mul_cnt_q != '0) && !rst;
   assign stall_mem = !dmem_ready;
   assign state_o   = state_q;

   // Compare every ID source against the load destination and the outstanding multiply.
   always_comb begin
      ld_match_c  = 1'b0;
      mul_match_c = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (if_id_rs[k*REG_AW +: REG_AW] == id_ex_rd) ld_match_c  = 1'b1;
         if (if_id_rs[k*REG_AW +: REG_AW] == mul_rd_q) mul_match_c = 1'b1;
      end
      load_use_c = id_ex_memread && (id_ex_rd != '0) && ld_match_c;
      mul_haz_c  = mul_busy && (mul_match_c || id_ex_mul);
   end

   always_comb begin
      stall_if = 1'b0;
      stall_id = 1'b0;
      flush_ex = 1'b0;
      if (!dmem_ready) begin
         stall_if = 1'b1;
         stall_id = 1'b1;
      end else if (load_use_c || mul_haz_c) begin
         stall_if = 1'b1;
         flush_ex = 1'b1;
      end
   end

   // Multiplier scoreboard: one outstanding result, frozen while memory stalls.
   always_comb begin
      mul_cnt_d = mul_cnt_q;
      mul_rd_d  = mul_rd_q;
      if (id_ex_mul && (id_ex_rd != '0) && dmem_ready && !mul_busy) begin
         mul_cnt_d = MUL_CNT_W'(MUL_LAT);
         mul_rd_d  = id_ex_rd;
      end else if ((mul_cnt_q != '0) && dmem_ready) begin
         mul_cnt_d = mul_cnt_q - MUL_CNT_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      if (!dmem_ready) begin
         state_d = ST_MEM_WAIT;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (load_use_c)     state_d = ST_LOAD_STALL;
               else if (mul_haz_c) state_d = ST_MUL_WAIT;
            end
            ST_LOAD_STALL: state_d = ST_IDLE;
            ST_MUL_WAIT: begin
               if (mul_cnt_q == '0) state_d = ST_IDLE;
            end
            ST_MEM_WAIT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         mul_cnt_q <= '0;
         mul_rd_q  <= '0;
      end else begin
         state_q   <= state_d;
         mul_cnt_q <= mul_cnt_d;
         mul_rd_q  <= mul_rd_d;
      end
   end

endmodule

// File: tb/tb_fb_hazard_unit.sv
// Directed and randomized checks of fb_hazard_unit against a cycle-level behavioural model.
module tb_fb_hazard_unit;

   localparam int unsigned NUM_SRC = 2;
   localparam int unsigned REG_AW  = 5;
   localparam int unsigned MUL_LAT = 3;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [NUM_SRC*REG_AW-1:0] if_id_rs;
   logic [NUM_SRC*REG_AW-1:0] id_ex_rs;
   logic                      id_ex_memread;
   logic                      id_ex_mul;
   logic [REG_AW-1:0]         id_ex_rd;
   logic                      ex_mem_regwrite;
   logic [REG_AW-1:0]         ex_mem_rd;
   logic                      mem_wb_regwrite;
   logic [REG_AW-1:0]         mem_wb_rd;
   logic                      dmem_ready;
   logic [NUM_SRC*2-1:0]      forward_sel;
   logic                      stall_if;
   logic                      stall_id;
   logic                      flush_ex;
   logic                      stall_mem;
   logic                      mul_busy;
   logic [1:0]                state_o;

   int passed = 0;
   int total  = 0;

   // Model state: stall cause (0 idle, 1 load, 2 mul, 3 mem) and cycles left on the multiply.
   int m_state = 0;
   int m_left  = 0;
   int m_dest  = 0;

   always #5 clk = ~clk;

   fb_hazard_unit #(
      .NUM_SRC (NUM_SRC),
      .REG_AW  (REG_AW),
      .MUL_LAT (MUL_LAT)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .if_id_rs        (if_id_rs),
      .id_ex_rs        (id_ex_rs),
      .id_ex_memread   (id_ex_memread),
      .id_ex_mul       (id_ex_mul),
      .id_ex_rd        (id_ex_rd),
      .ex_mem_regwrite (ex_mem_regwrite),
      .ex_mem_rd       (ex_mem_rd),
      .mem_wb_regwrite (mem_wb_regwrite),
      .mem_wb_rd       (mem_wb_rd),
      .dmem_ready      (dmem_ready),
      .forward_sel     (forward_sel),
      .stall_if        (stall_if),
      .stall_id        (stall_id),
      .flush_ex        (flush_ex),
      .stall_mem       (stall_mem),
      .mul_busy        (mul_busy),
      .state_o         (state_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int slot(input logic [NUM_SRC*REG_AW-1:0] v, input int k);
      logic [REG_AW-1:0] r;
      r = v[k*REG_AW +: REG_AW];
      return int'(r);
   endfunction

   function automatic int m_fwd(input int k);
      int rs;
      rs = slot(id_ex_rs, k);
      if (ex_mem_regwrite && ex_mem_rd != 0 && int'(ex_mem_rd) == rs) return 2;
      if (mem_wb_regwrite && mem_wb_rd != 0 && int'(mem_wb_rd) == rs) return 1;
      return 0;
   endfunction

   function automatic bit m_load_use();
      bit hit = 0;
      for (int k = 0; k < NUM_SRC; k++)
         if (slot(if_id_rs, k) == int'(id_ex_rd)) hit = 1;
      return id_ex_memread && id_ex_rd != 0 && hit;
   endfunction

   function automatic bit m_mul_haz(input bit busy);
      bit hit = 0;
      for (int k = 0; k < NUM_SRC; k++)
         if (slot(if_id_rs, k) == m_dest) hit = 1;
      return busy && (hit || id_ex_mul);
   endfunction

   task automatic check_all(input string tag);
      logic [NUM_SRC*2-1:0] efwd;
      bit busy, haz;
      #1;
      efwd = '0;
      for (int k = 0; k < NUM_SRC; k++) efwd[2*k +: 2] = 2'(m_fwd(k));
      busy = (m_left > 0) && !rst;
      haz  = m_load_use() || m_mul_haz(busy);
      chk({tag, ".fwd"},       32'(forward_sel), 32'(efwd));
      chk({tag, ".stall_if"},  32'(stall_if),    32'(!dmem_ready || haz));
      chk({tag, ".stall_id"},  32'(stall_id),    32'(!dmem_ready));
      chk({tag, ".flush_ex"},  32'(flush_ex),    32'(dmem_ready && haz));
      chk({tag, ".stall_mem"}, 32'(stall_mem),   32'(!dmem_ready));
      chk({tag, ".mul_busy"},  32'(mul_busy),    32'(busy));
      chk({tag, ".state"},     32'(state_o),     32'(m_state));
   endtask

   // Advance the model with the inputs present at the edge, then the clock.
   task automatic tick();
      int ns, nl, nd;
      bit busy;
      busy = m_left > 0;
      ns = m_state; nl = m_left; nd = m_dest;
      if (rst) begin
         ns = 0; nl = 0; nd = 0;
      end else begin
         if (!dmem_ready) ns = 3;
         else if (m_state == 0) ns = m_load_use() ? 1 : (m_mul_haz(busy) ? 2 : 0);
         else if (m_state == 2) ns = (m_left == 0) ? 0 : 2;
         else ns = 0;
         if (id_ex_mul && id_ex_rd != 0 && dmem_ready && !busy) begin
            nl = MUL_LAT; nd = int'(id_ex_rd);
         end else if (m_left > 0 && dmem_ready) begin
            nl = m_left - 1;
         end
      end
      @(posedge clk);
      #1;
      m_state = ns; m_left = nl; m_dest = nd;
   endtask

   task automatic quiet();
      if_id_rs = '0; id_ex_rs = '0;
      id_ex_memread = 0; id_ex_mul = 0; id_ex_rd = '0;
      ex_mem_regwrite = 0; ex_mem_rd = '0;
      mem_wb_regwrite = 0; mem_wb_rd = '0;
      dmem_ready = 1;
   endtask

   initial begin
      rst = 1;
      quiet();
      @(posedge clk); #1;
      tick();
      rst = 0;
      check_all("reset");
      chk("reset.state_lit", 32'(state_o), 32'd0);
      chk("reset.busy_lit",  32'(mul_busy), 32'd0);
      tick();

      // EX/MEM beats MEM/WB on the same register
      id_ex_rs = {5'd2, 5'd1};
      ex_mem_regwrite = 1; ex_mem_rd = 5'd1;
      mem_wb_regwrite = 1; mem_wb_rd = 5'd1;
      check_all("fwd_pri");
      chk("fwd_pri.lit", 32'(forward_sel), 32'h2);
      tick();

      // x0 never forwarded; MEM/WB path on slot1
      id_ex_rs = {5'd3, 5'd0};
      ex_mem_rd = 5'd0;
      mem_wb_rd = 5'd3;
      check_all("fwd_x0");
      chk("fwd_x0.lit", 32'(forward_sel), 32'h4);
      tick();

      // Load-use: one bubble, LOAD_STALL for one cycle
      quiet();
      id_ex_memread = 1; id_ex_rd = 5'd5; if_id_rs = {5'd5, 5'd9};
      check_all("ld_use");
      chk("ld_use.stall_if", 32'(stall_if), 32'd1);
      chk("ld_use.flush",    32'(flush_ex), 32'd1);
      tick();
      quiet();
      check_all("ld_stall");
      chk("ld_stall.state", 32'(state_o), 32'd1);
      tick();
      check_all("ld_done");
      chk("ld_done.state", 32'(state_o), 32'd0);

      // Multiply to x7, next ID reads x7: three stall cycles
      id_ex_mul = 1; id_ex_rd = 5'd7;
      check_all("mul_issue");
      tick();
      quiet();
      if_id_rs = {5'd0, 5'd7};
      for (int i = 0; i < 3; i++) begin
         check_all("mul_wait");
         chk("mul_wait.stall_if", 32'(stall_if), 32'd1);
         chk("mul_wait.busy",     32'(mul_busy), 32'd1);
         tick();
      end
      check_all("mul_free");
      chk("mul_free.stall_if", 32'(stall_if), 32'd0);
      chk("mul_free.busy",     32'(mul_busy), 32'd0);
      tick();
      check_all("mul_idle");
      chk("mul_idle.state", 32'(state_o), 32'd0);
      tick();

      // Memory wait during MUL_WAIT freezes the counter
      quiet();
      id_ex_mul = 1; id_ex_rd = 5'd7;
      check_all("mw_issue");
      tick();
      quiet();
      if_id_rs = {5'd7, 5'd0};
      check_all("mw_haz");
      tick();
      dmem_ready = 0;
      for (int i = 0; i < 4; i++) begin
         check_all("mw_mem");
         chk("mw_mem.stall_id", 32'(stall_id), 32'd1);
         chk("mw_mem.busy",     32'(mul_busy), 32'd1);
         tick();
      end
      dmem_ready = 1;
      check_all("mw_res0");
      chk("mw_res0.busy", 32'(mul_busy), 32'd1);
      tick();
      check_all("mw_res1");
      chk("mw_res1.busy", 32'(mul_busy), 32'd1);
      tick();
      check_all("mw_res2");
      chk("mw_res2.busy", 32'(mul_busy), 32'd0);
      tick();
      quiet();
      check_all("mw_end");
      tick();

      // Reset in MUL_WAIT with two cycles left
      id_ex_mul = 1; id_ex_rd = 5'd7;
      check_all("rs_issue");
      tick();
      quiet();
      if_id_rs = {5'd7, 5'd7};
      check_all("rs_haz");
      tick();
      check_all("rs_wait");
      chk("rs_wait.state", 32'(state_o), 32'd2);
      rst = 1;
      check_all("rs_pulse");
      tick();
      rst = 0;
      check_all("rs_after");
      chk("rs_after.state", 32'(state_o), 32'd0);
      chk("rs_after.busy",  32'(mul_busy), 32'd0);
      chk("rs_after.stall", 32'(stall_if), 32'd0);
      tick();

      // Randomized traffic on a small register range to provoke matches
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(39, 0) == 0);
         dmem_ready = ($urandom_range(5, 0) != 0);
         for (int k = 0; k < NUM_SRC; k++) begin
            if_id_rs[k*REG_AW +: REG_AW] = REG_AW'($urandom_range(3, 0));
            id_ex_rs[k*REG_AW +: REG_AW] = REG_AW'($urandom_range(3, 0));
         end
         id_ex_memread   = 1'($urandom_range(1, 0));
         id_ex_mul       = ($urandom_range(3, 0) == 0);
         id_ex_rd        = REG_AW'($urandom_range(3, 0));
         ex_mem_regwrite = 1'($urandom_range(1, 0));
         ex_mem_rd       = REG_AW'($urandom_range(3, 0));
         mem_wb_regwrite = 1'($urandom_range(1, 0));
         mem_wb_rd       = REG_AW'($urandom_range(3, 0));
         check_all("rand");
         tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fb_hazard_unit.md
FB_HAZARD_UNIT -- requirements
Module: fb_hazard_unit

Interface
REQ-001 Parameter NUM_SRC, default 2, number of source-register read ports per instruction (1..4).
REQ-002 Parameter REG_AW, default 5, register-address width.
REQ-003 Parameter MUL_LAT, default 3, cycles from multiplier issue in EX to result valid on the MEM/WB write port (2..15).
REQ-004 Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- if_id_rs  in  NUM_SRC*REG_AW  sources of the instruction in ID; slot k at bits [k*REG_AW +: REG_AW].
- id_ex_rs  in  NUM_SRC*REG_AW  sources of the instruction in EX; same slot packing.
- id_ex_memread  in  1  EX instruction is a load.
- id_ex_mul  in  1  EX instruction issues to the multi-cycle multiplier.
- id_ex_rd  in  REG_AW  EX destination.
- ex_mem_regwrite  in  1  EX/MEM writes a register.
- ex_mem_rd  in  REG_AW  EX/MEM destination.
- mem_wb_regwrite  in  1  MEM/WB writes a register.
- mem_wb_rd  in  REG_AW  MEM/WB destination.
- dmem_ready  in  1  data memory has completed the access in MEM.
- forward_sel  out  NUM_SRC*2  per-slot operand mux select for EX.
- stall_if  out  1  hold PC and IF/ID.
- stall_id  out  1  hold ID/EX.
- flush_ex  out  1  insert a bubble into ID/EX.
- stall_mem  out  1  hold EX/MEM and MEM/WB.
- mul_busy  out  1  multiplier result outstanding.
- state_o  out  2  current FSM state, for debug.

Function
REQ-005 forward_sel is combinational per slot: 2'b10 when ex_mem_regwrite, ex_mem_rd != 0 and ex_mem_rd == id_ex_rs[k]; else 2'b01 when mem_wb_regwrite, mem_wb_rd != 0 and mem_wb_rd == id_ex_rs[k]; else 2'b00.
REQ-006 EX/MEM takes priority over MEM/WB when both match; register 0 is never forwarded.
REQ-007 Load-use hazard: id_ex_memread, id_ex_rd != 0, and id_ex_rd equal to any if_id_rs slot.
REQ-008 Scoreboard: a register mul_rd and a down-counter mul_cnt (4 bits); mul_busy = (mul_cnt != 0).
REQ-009 On id_ex_mul with id_ex_rd != 0, no stall_mem and mul_busy low: mul_rd <= id_ex_rd and mul_cnt <= MUL_LAT. Otherwise mul_cnt decrements by 1 each cycle while nonzero and stall_mem is low, and saturates at 0.
REQ-010 Mul hazard: mul_busy and mul_rd equal to any if_id_rs slot, or id_ex_mul while mul_busy (structural).
REQ-011 FSM states: IDLE=2'd0, LOAD_STALL=2'd1, MUL_WAIT=2'd2, MEM_WAIT=2'd3.
REQ-012 Transitions, in priority order: any state with dmem_ready low goes to MEM_WAIT; MEM_WAIT with dmem_ready high goes to IDLE. IDLE with a load-use hazard goes to LOAD_STALL; IDLE with a mul hazard goes to MUL_WAIT. LOAD_STALL goes to IDLE after exactly one cycle. MUL_WAIT goes to IDLE in the cycle after mul_cnt reaches 0.
REQ-013 stall_mem is combinational: high whenever dmem_ready is low.
REQ-014 When dmem_ready is low, stall_if and stall_id are both high; flush_ex is low.
REQ-015 When a load-use or mul hazard is present and dmem_ready is high: stall_if=1, stall_id=0, flush_ex=1. These outputs are combinational from the hazard terms, so the bubble appears in the same cycle the hazard is detected.
REQ-016 With no hazard and dmem_ready high, stall_if, stall_id and flush_ex are 0.
REQ-017 Simultaneous load-use and mul hazards: the load-use hazard is recorded as the state. The mul hazard is re-evaluated on return to IDLE.

Reset
REQ-018 When rst is high at a clk edge: the state goes to IDLE, mul_cnt and mul_rd go to 0, and mul_busy goes to 0.
REQ-019 Reset asserted mid-stall (any state) SHALL discard the outstanding multiplier tracking.
REQ-020 During and after reset, the outputs are purely the combinational functions of their inputs, with mul_busy=0.

Structure
REQ-021 The FSM state encodings and the forward_sel codes (FWD_RF=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10) live in the shared package fb_pipeline_pkg.
REQ-022 One sub-module, fb_fwd_select, computes the select for a single slot; it is instantiated NUM_SRC times by a generate loop.

Verification
REQ-023 id_ex_rs={x2,x1}, ex_mem rd=1 regwrite=1, mem_wb rd=1 regwrite=1 -> forward_sel slot0=10, slot1=00.
REQ-024 ex_mem_rd=0 with regwrite=1, id_ex_rs slot0=0 -> slot0=00.
REQ-025 id_ex_memread=1, id_ex_rd=5, if_id_rs slot1=5 -> one cycle of stall_if=1 and flush_ex=1, state LOAD_STALL, then IDLE.
REQ-026 MUL_LAT=3, mul issue with rd=7, next ID reads x7 -> stall_if=1 for 3 cycles, mul_busy falls after 3 cycles, no stall on the 4th.
REQ-027 dmem_ready low for 4 cycles during MUL_WAIT -> stall_if=stall_id=stall_mem=1, mul_cnt frozen, resume counting after ready.
REQ-028 rst pulsed while in MUL_WAIT with mul_cnt=2 -> next cycle state=IDLE, mul_busy=0.
